// File: rtl/ringosc_meas_pkg.sv
// Shared types and constants for the ring-oscillator frequency measurement block.
package ringosc_meas_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_MEASURE = 2'd2,
      ST_DONE    = 2'd3
   } meas_state_t;

   localparam int DEFAULT_COUNT_W    = 12;
   localparam int DEFAULT_SETTLE_CYC = 16;

   // Gate window cycle counter width, sized for the longest window (16384).
   localparam int MEAS_W = 14;

   localparam logic [MEAS_W-1:0] GATE_LAST_0 = 14'd255;
   localparam logic [MEAS_W-1:0] GATE_LAST_1 = 14'd1023;
   localparam logic [MEAS_W-1:0] GATE_LAST_2 = 14'd4095;
   localparam logic [MEAS_W-1:0] GATE_LAST_3 = 14'd16383;

   // Index of the last cycle of a gate window: 2^(8+2*sel) - 1.
   function automatic logic [MEAS_W-1:0] gate_last(input logic [1:0] sel);
      logic [MEAS_W-1:0] last;
      case (sel)
         2'd0:    last = GATE_LAST_0;
         2'd1:    last = GATE_LAST_1;
         2'd2:    last = GATE_LAST_2;
         default: last = GATE_LAST_3;
      endcase
      return last;
   endfunction

endpackage

// File: rtl/ringosc_edge_cnt.sv
// Synchronizes the raw oscillator, detects rising edges and counts them with saturation.
module ringosc_edge_cnt #(
   parameter int COUNT_W = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               osc_in,
   input  logic               clear,
   input  logic               enable,
   output logic [COUNT_W-1:0] count,
   output logic               sat
);

   localparam logic [COUNT_W-1:0] CNT_MAX = '1;

   logic               sync1_reg, sync2_reg, prev_reg;
   logic [COUNT_W-1:0] cnt_reg, cnt_next;
   logic               sat_reg, sat_next;
   logic               edge_hit;

   assign edge_hit = enable & sync2_reg & ~prev_reg;

   // Clear still counts an edge seen in the same cycle so no window cycle is lost.
   always_comb begin
      cnt_next = cnt_reg;
      sat_next = sat_reg;
      if (clear) begin
         cnt_next = {{(COUNT_W-1){1'b0}}, edge_hit};
         sat_next = 1'b0;
      end else if (edge_hit) begin
         if (cnt_reg == CNT_MAX)
            sat_next = 1'b1;
         else
            cnt_next = cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         prev_reg  <= 1'b0;
         cnt_reg   <= '0;
         sat_reg   <= 1'b0;
      end else begin
         sync1_reg <= osc_in;
         sync2_reg <= sync1_reg;
         prev_reg  <= sync2_reg;
         cnt_reg   <= cnt_next;
         sat_reg   <= sat_next;
      end
   end

   assign count = cnt_reg;
   assign sat   = sat_reg;

endmodule

// File: rtl/ringosc_meas_ctrl.sv
// Ring-oscillator measurement controller: settle, gated edge count, publish.
// Define RINGOSC_MEAS_CTRL_AVG_EN to average four back-to-back gate windows.
module ringosc_meas_ctrl
   import ringosc_meas_pkg::*;
#(
   parameter int COUNT_W    = DEFAULT_COUNT_W,
   parameter int SETTLE_CYC = DEFAULT_SETTLE_CYC
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [1:0]         gate_sel,
   input  logic               osc_in,
   output logic               osc_en,
   output logic               busy,
   output logic               done,
   output logic [COUNT_W-1:0] count,
   output logic               overflow
);

   meas_state_t        state_reg, state_next;
   logic [7:0]         settle_cnt_reg;
   logic [MEAS_W-1:0]  meas_cnt_reg;
   logic [1:0]         gate_reg;
   logic               osc_en_reg;
   logic [COUNT_W-1:0] count_reg;
   logic               overflow_reg;

   logic               settle_last, win_last, win_first, meas_final;
   logic               ec_clear, ec_enable;
   logic [COUNT_W-1:0] ec_count;
   logic               ec_sat;
   logic [COUNT_W-1:0] result;
   logic               result_ovf;

   assign settle_last = (settle_cnt_reg == 8'(SETTLE_CYC - 1));
   assign win_last    = (meas_cnt_reg == gate_last(gate_reg));
   assign win_first   = (meas_cnt_reg == '0);
   assign ec_enable   = (state_reg == ST_MEASURE);
   assign ec_clear    = (state_reg != ST_MEASURE) || win_first;

   ringosc_edge_cnt #(
      .COUNT_W (COUNT_W)
   ) u_edge_cnt (
      .clk    (clk),
      .rst    (rst),
      .osc_in (osc_in),
      .clear  (ec_clear),
      .enable (ec_enable),
      .count  (ec_count),
      .sat    (ec_sat)
   );

`ifdef RINGOSC_MEAS_CTRL_AVG_EN
   logic [1:0]         win_reg;
   logic [COUNT_W+1:0] sum_reg, sum_total;
   logic               sat_acc_reg;

   // A window's count is final in the first cycle of the following window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_reg     <= '0;
         sum_reg     <= '0;
         sat_acc_reg <= 1'b0;
      end else if (state_reg != ST_MEASURE) begin
         win_reg     <= '0;
         sum_reg     <= '0;
         sat_acc_reg <= 1'b0;
      end else begin
         if (win_last)
            win_reg <= win_reg + 2'd1;
         if (win_first && (win_reg != 2'd0)) begin
            sum_reg     <= sum_reg + {2'b00, ec_count};
            sat_acc_reg <= sat_acc_reg | ec_sat;
         end
      end
   end

   assign meas_final = win_last && (win_reg == 2'd3);
   assign sum_total  = sum_reg + {2'b00, ec_count};
   assign result     = COUNT_W'(sum_total >> 2);
   assign result_ovf = sat_acc_reg | ec_sat;
`else
   assign meas_final = win_last;
   assign result     = ec_count;
   assign result_ovf = ec_sat;
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:    if (start && !abort) state_next = ST_SETTLE;
         ST_SETTLE:  if (abort)           state_next = ST_IDLE;
                     else if (settle_last) state_next = ST_MEASURE;
         ST_MEASURE: if (abort)           state_next = ST_IDLE;
                     else if (meas_final) state_next = ST_DONE;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         settle_cnt_reg <= '0;
         meas_cnt_reg   <= '0;
         gate_reg       <= '0;
         osc_en_reg     <= 1'b0;
         count_reg      <= '0;
         overflow_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         osc_en_reg     <= (state_next == ST_SETTLE) || (state_next == ST_MEASURE);
         settle_cnt_reg <= (state_reg == ST_SETTLE) ? settle_cnt_reg + 8'd1 : 8'd0;
         if (state_reg == ST_MEASURE && !win_last)
            meas_cnt_reg <= meas_cnt_reg + 1'b1;
         else
            meas_cnt_reg <= '0;
         if (state_reg == ST_IDLE && start && !abort)
            gate_reg <= gate_sel;
         if (state_reg == ST_DONE) begin
            count_reg    <= result;
            overflow_reg <= result_ovf;
         end
      end
   end

   // The result is shown live during DONE and held in count_reg afterwards.
   assign osc_en   = osc_en_reg;
   assign busy     = (state_reg != ST_IDLE);
   assign done     = (state_reg == ST_DONE);
   assign count    = (state_reg == ST_DONE) ? result : count_reg;
   assign overflow = (state_reg == ST_DONE) ? result_ovf : overflow_reg;

endmodule

// File: tb/tb_ringosc_meas_ctrl.sv
// Scoreboard bench for ringosc_meas_ctrl: expected results queued at start, checked at done.
module tb_ringosc_meas_ctrl;

   localparam int COUNT_W    = 12;
   localparam int SETTLE_CYC = 16;
   localparam int CNT_MAX    = (1 << COUNT_W) - 1;
`ifdef RINGOSC_MEAS_CTRL_AVG_EN
   localparam int N_WIN = 4;
`else
   localparam int N_WIN = 1;
`endif

   logic               clk = 1'b0;
   logic               rst, start, abort, osc_in;
   logic [1:0]         gate_sel;
   logic               osc_en, busy, done, overflow;
   logic [COUNT_W-1:0] count;

   typedef struct {
      int cnt;
      int ovf;
      int run;
   } exp_t;

   exp_t sb_q[$];
   int   checks    = 0;
   int   failures  = 0;
   int   done_cnt  = 0;
   int   osc_mode  = 0;   // 0: held low, 1: clk/2, 2: clk/4
   int   last_cnt  = 0;

   ringosc_meas_ctrl #(
      .COUNT_W    (COUNT_W),
      .SETTLE_CYC (SETTLE_CYC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .gate_sel (gate_sel),
      .osc_in   (osc_in),
      .osc_en   (osc_en),
      .busy     (busy),
      .done     (done),
      .count    (count),
      .overflow (overflow)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
      end
   endtask

   // Oscillator stimulus, changed just after each rising clk edge.
   initial begin
      int phase;
      phase  = 0;
      osc_in = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         phase++;
         case (osc_mode)
            1:       osc_in = ~osc_in;
            2:       if (phase % 2 == 0) osc_in = ~osc_in;
            default: osc_in = 1'b0;
         endcase
      end
   end

   // Monitor: measures the osc_en run length and scores every done pulse.
   initial begin
      int   run;
      exp_t e;
      run = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            run = 0;
         end else if (osc_en) begin
            run++;
         end else begin
            if (done) begin
               done_cnt++;
               check("busy_in_done", busy, 1);
               if (sb_q.size() == 0) begin
                  check("unexpected_done", 1, 0);
               end else begin
                  e = sb_q.pop_front();
                  $display("txn %0d: count=%0d overflow=%0b osc_en_cycles=%0d (exp %0d/%0d/%0d)",
                           done_cnt, count, overflow, run, e.cnt, e.ovf, e.run);
                  check("count", count, e.cnt);
                  check("overflow", overflow, e.ovf);
                  check("osc_en_cycles", run, e.run);
               end
            end
            run = 0;
         end
      end
   end

   function automatic exp_t model(input int mode, input int gs);
      exp_t e;
      int   len, edges;
      len   = 256 << (2 * gs);
      edges = (mode == 1) ? len / 2 : len / 4;
      e.cnt = (edges > CNT_MAX) ? CNT_MAX : edges;
      e.ovf = (edges > CNT_MAX) ? 1 : 0;
      e.run = SETTLE_CYC + len * N_WIN;
      return e;
   endfunction

   task automatic pulse_start(input logic [1:0] gs);
      @(negedge clk);
      gate_sel = gs;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int n;
      n = 0;
      while (!done && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (!done) check("done_timeout", 0, 1);
      @(negedge clk);
   endtask

   task automatic run_meas(input int mode, input int gs);
      exp_t e;
      e        = model(mode, gs);
      osc_mode = mode;
      sb_q.push_back(e);
      last_cnt = e.cnt;
      pulse_start(2'(gs));
      wait_done(SETTLE_CYC + 16384 * N_WIN + 50);
   endtask

   initial begin
      int d0;
      rst      = 1'b1;
      start    = 1'b0;
      abort    = 1'b0;
      gate_sel = 2'd0;
      repeat (3) @(negedge clk);
      check("rst_osc_en", osc_en, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_count", count, 0);
      check("rst_overflow", overflow, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // clk/4, shortest gate
      run_meas(2, 0);

      // abort during MEASURE cycle 100
      osc_mode = 2;
      d0 = done_cnt;
      pulse_start(2'd0);
      repeat (116) @(negedge clk);
      check("abort_busy_before", busy, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_osc_en", osc_en, 0);
      check("abort_count_kept", count, last_cnt);
      repeat (20) @(negedge clk);
      check("abort_no_done", done_cnt - d0, 0);

      // start pulses while busy are ignored
      d0 = done_cnt;
      sb_q.push_back(model(2, 0));
      last_cnt = model(2, 0).cnt;
      pulse_start(2'd0);
      repeat (10) @(negedge clk);
      pulse_start(2'd3);
      repeat (200) @(negedge clk);
      pulse_start(2'd3);
      wait_done(SETTLE_CYC + 256 * N_WIN + 50);
      repeat (20) @(negedge clk);
      check("single_done", done_cnt - d0, 1);

      // start and abort together in IDLE
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_busy", busy, 0);
      check("start_abort_osc_en", osc_en, 0);

      // asynchronous reset mid-SETTLE
      osc_mode = 2;
      pulse_start(2'd1);
      repeat (5) @(negedge clk);
      check("settle_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_osc_en", osc_en, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_count", count, 0);
      check("arst_overflow", overflow, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      run_meas(2, 1);

      // clk/2 on the longest gate saturates
      run_meas(1, 3);
      check("final_count_held", count, CNT_MAX);
      check("sb_empty", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ringosc_meas_ctrl.md
RINGOSC_MEAS_CTRL -- requirements
Module: ringosc_meas_ctrl

Interface
REQ-001 SHALL have parameter COUNT_W, default 12: width of the edge count result.
REQ-002 SHALL have parameter SETTLE_CYC, default 16: number of clk cycles the ring oscillator runs before counting starts (range 1..255).
REQ-003 SHALL have port clk, input, 1: single system clock; all state is in this domain.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a measurement.
REQ-006 SHALL have port abort, input, 1: cancels an in-progress measurement.
REQ-007 SHALL have port gate_sel, input, 2: selects the gate window length.
REQ-008 SHALL have port osc_in, input, 1: asynchronous ring-oscillator output being measured.
REQ-009 SHALL have port osc_en, output, 1: enable to the ring oscillator.
REQ-010 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-011 SHALL have port done, output, 1: one-cycle pulse when a result is published.
REQ-012 SHALL have port count, output, COUNT_W: last published result.
REQ-013 SHALL have port overflow, output, 1: the last published result saturated.

Function
REQ-014 SHALL implement the FSM states IDLE, SETTLE, MEASURE and DONE.
REQ-015 IDLE->SETTLE SHALL occur on start=1 and abort=0; gate_sel is latched on the same edge.
REQ-016 start SHALL be ignored outside IDLE.
REQ-017 osc_en SHALL be 1 exactly while in SETTLE or MEASURE, registered, and never combinational from inputs.
REQ-018 SETTLE SHALL last exactly SETTLE_CYC cycles, then go to MEASURE.
REQ-019 MEASURE SHALL last exactly 2^(8+2*gate_sel) cycles (256, 1024, 4096 or 16384) and count rising edges of the synchronized osc_in.
REQ-020 osc_in SHALL pass through a 2-flop synchronizer plus a rising-edge detector; only edges detected during a MEASURE cycle count.
REQ-021 The counter SHALL clear on entry to MEASURE and saturate at 2^COUNT_W-1, setting an internal sat flag; it SHALL not wrap.
REQ-022 In DONE (one cycle), count and overflow SHALL be updated, done SHALL be 1, and the next state SHALL be IDLE.
REQ-023 abort=1 in SETTLE or MEASURE SHALL cause a return to IDLE on the next edge, with osc_en low, no done pulse, and count/overflow unchanged.
REQ-024 abort in DONE SHALL be ignored, so the result still publishes.
REQ-025 A start in the cycle that DONE returns to IDLE SHALL be accepted one cycle later only if start is still high in IDLE.

Reset
REQ-026 rst SHALL asynchronously force IDLE, osc_en=0, busy=0, done=0, count=0, overflow=0, counter=0, and synchronizer flops=0; this applies mid-measurement too.

Configuration
REQ-027 Macro RINGOSC_MEAS_CTRL_AVG_EN defined: MEASURE SHALL run 4 back-to-back windows without re-settling, accumulate into a COUNT_W+2 bit sum, and publish count=sum>>2; overflow=1 if any window saturated.
REQ-028 Macro RINGOSC_MEAS_CTRL_AVG_EN undefined: a single window SHALL be used and no accumulator SHALL be present.

Structure
REQ-029 Package ringosc_meas_pkg SHALL hold the FSM state enum, the gate length constants per gate_sel, and the default COUNT_W/SETTLE_CYC.
REQ-030 Sub-module ringosc_edge_cnt SHALL contain the synchronizer, edge detector and saturating counter (clear, enable, count, sat).

Verification
REQ-031 osc_in=clk/4 square wave, gate_sel=0, start -> osc_en high for 16+256 cycles; done pulse; count=64, overflow=0.
REQ-032 osc_in=clk/2, gate_sel=3 -> count=4095, overflow=1.
REQ-033 abort asserted at MEASURE cycle 100 -> IDLE next cycle, osc_en=0, no done, count retains its prior value (64).
REQ-034 start pulsed while busy -> ignored, with a single done for the original request; start and abort together in IDLE -> stays IDLE.
REQ-035 rst asserted mid-SETTLE -> all outputs 0 immediately (asynchronously); a subsequent normal run gives the correct count.
REQ-036 With AVG_EN: osc_in=clk/4, gate_sel=0 -> MEASURE lasts 1024 cycles and count=64; without AVG_EN -> MEASURE lasts 256 cycles.
